// File: rtl/melody_sequencer.sv
// Pattern player for the square-wave tone generator: walks a host-loaded note RAM,
// timing each entry in prescaled beat ticks with an optional silent articulation gap.
//
// state   | meaning
// IDLE    | waiting for start; pattern RAM writable
// FETCH   | one cycle; registered RAM word for step is examined
// TONE    | entry sounding (or resting) for len beat ticks
// GAP     | silent articulation gap after an entry
// DONE    | one-cycle completion pulse, then back to IDLE
module melody_sequencer #(
  parameter int TICK_DIV   = 3_125_000,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 250_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  output logic [2:0]                 note,
  output logic                       tone_en,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW-1:0] STEP_LAST  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_TONE, S_GAP, S_DONE} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] presc;
  logic [3:0]    ticks_left;
  logic [GW-1:0] gap_cnt;

  logic       rd_rest;
  logic [2:0] rd_note;
  logic [3:0] rd_len;
  logic       tone_end, gap_end, advance, end_marker;

  assign rd_rest = rd_data[7];
  assign rd_note = rd_data[6:4];
  assign rd_len  = rd_data[3:0];

  assign tone_end   = (state == S_TONE) && (presc == PRESC_LAST) && (ticks_left == 4'd1);
  assign gap_end    = (state == S_GAP) && (gap_cnt == '0);
  assign advance    = (GAP_CYCLES > 0) ? gap_end : tone_end;
  assign end_marker = ((state == S_FETCH) && (rd_len == 4'd0)) ||
                      (advance && (step == STEP_LAST));

  // Address of the entry the next FETCH will examine, so the registered read is ready in time.
  always_comb begin
    rd_addr = step;
    if (state == S_IDLE)
      rd_addr = '0;
    else if ((state == S_FETCH) && (rd_len == 4'd0))
      rd_addr = '0;
    else if (advance)
      rd_addr = (step == STEP_LAST) ? '0 : step + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE))
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      step       <= '0;
      note       <= '0;
      tone_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      presc      <= '0;
      ticks_left <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        state   <= S_IDLE;
        tone_en <= 1'b0;
        busy    <= 1'b0;
      end else if (end_marker) begin
        tone_en <= 1'b0;
        // Entry 0 being the end marker never loops, so an empty pattern cannot spin.
        if (loop && (step != '0)) begin
          state <= S_FETCH;
          step  <= '0;
        end else begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (advance) begin
        tone_en <= 1'b0;
        state   <= S_FETCH;
        step    <= step + AW'(1);
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state <= S_FETCH;
              step  <= '0;
              busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            state      <= S_TONE;
            note       <= rd_note;
            tone_en    <= ~rd_rest;
            presc      <= '0;
            ticks_left <= rd_len;
          end
          S_TONE: begin
            if (presc == PRESC_LAST) begin
              presc      <= '0;
              ticks_left <= ticks_left - 4'd1;
              if (ticks_left == 4'd1) begin
                state   <= S_GAP;
                gap_cnt <= GAP_LAST;
                tone_en <= 1'b0;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          S_GAP:   gap_cnt <= gap_cnt - GW'(1);
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios plus randomized patterns, each compared
// cycle by cycle against a per-entry timeline built from the playback rules.
module tb_melody_sequencer;

  localparam int TD  = 4;
  localparam int GC  = 2;
  localparam int DP  = 16;
  localparam int CAP = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [2:0] note;
  logic       tone_en;
  logic       busy;
  logic       done;
  logic [3:0] step;

  int total = 0;
  int bad = 0;

  logic [7:0]  mdl_mem [DP];
  logic [2:0]  mdl_note = '0;
  logic [11:0] exp_q [$];

  melody_sequencer #(.TICK_DIV(TD), .DEPTH(DP), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .note(note), .tone_en(tone_en),
    .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed observation: {busy, done, tone_en, note[2:0], step[3:0]} as 12 bits (pad bit 0 of MSB nibble).
  function automatic logic [11:0] pk(input logic b, input logic d, input logic t,
                                     input logic [2:0] n, input logic [3:0] s);
    return {1'b0, b, d, t, 1'b0, n, s};
  endfunction

  function automatic logic [11:0] obs();
    return pk(busy, done, tone_en, note, step);
  endfunction

  task automatic chk(input string tag, input int idx, input logic [11:0] got, input logic [11:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, got, want);
    end
  endtask

  // Expected per-cycle outputs from the first FETCH cycle through the DONE cycle.
  task automatic build_trace(input bit lp, output bit trunc);
    int idx;
    bit fin;
    logic [2:0] n;
    logic [7:0] e;
    exp_q.delete();
    idx = 0;
    fin = 0;
    n = mdl_note;
    while (!fin && exp_q.size() < CAP) begin
      e = mdl_mem[idx];
      exp_q.push_back(pk(1, 0, 0, n, idx[3:0]));
      if (e[3:0] == 4'd0) begin
        if (lp && idx != 0) idx = 0;
        else begin
          exp_q.push_back(pk(0, 1, 0, n, idx[3:0]));
          fin = 1;
        end
      end else begin
        n = e[6:4];
        repeat (int'(e[3:0]) * TD) exp_q.push_back(pk(1, 0, ~e[7], n, idx[3:0]));
        repeat (GC) exp_q.push_back(pk(1, 0, 0, n, idx[3:0]));
        if (idx == DP - 1) begin
          if (lp) idx = 0;
          else begin
            exp_q.push_back(pk(0, 1, 0, n, idx[3:0]));
            fin = 1;
          end
        end else begin
          idx++;
        end
      end
    end
    trunc = !fin;
  endtask

  task automatic load();
    for (int i = 0; i < DP; i++) begin
      wr_en = 1'b1;
      wr_addr = 4'(i);
      wr_data = mdl_mem[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic fill_random(input int maxlen, input bit allow_end);
    logic [3:0] len;
    for (int i = 0; i < DP; i++) begin
      len = 4'($urandom_range(1, maxlen));
      if (allow_end && $urandom_range(0, 7) == 0) len = 4'd0;
      mdl_mem[i] = {1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), len};
    end
  endtask

  // Called at a negedge with the DUT idle. junk adds writes/start pulses while busy.
  task automatic play(input bit lp, input bit junk, input int stop_req);
    bit trunc;
    int n;
    int stop_k;
    logic [11:0] last;
    build_trace(lp, trunc);
    n = exp_q.size();
    stop_k = -1;
    if (stop_req >= 0 && stop_req < n - 1) stop_k = stop_req;
    else if (trunc) stop_k = $urandom_range(2, n - 2);
    last = '0;
    wr_en = 1'b0;
    start = 1'b1;
    loop = lp;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("play", k, obs(), exp_q[k]);
      last = exp_q[k];
      wr_en   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr = 4'($urandom);
      wr_data = 8'($urandom);
      start   = junk ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      stop    = (k == stop_k);
      @(negedge clk);
      if (k == stop_k) break;
    end
    wr_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    chk("idle", 0, obs(), pk(0, 0, 0, last[6:4], last[3:0]));
    @(negedge clk);
    chk("idle", 1, obs(), pk(0, 0, 0, last[6:4], last[3:0]));
    mdl_note = last[6:4];
  endtask

  initial begin
    bit trunc_d;
    for (int i = 0; i < DP; i++) mdl_mem[i] = '0;

    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset", 0, obs(), 12'h000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset", 1, obs(), 12'h000);

    // two tones then end marker
    mdl_mem[0] = 8'h02;
    mdl_mem[1] = 8'h21;
    mdl_mem[2] = 8'h00;
    load();
    play(0, 0, -1);

    // async reset in the middle of the first tone, then replay without reloading
    build_trace(0, trunc_d);
    start = 1'b1;
    loop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("pre_rst", k, obs(), exp_q[k]);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 chk("rst_async", 0, obs(), 12'h000);
    @(negedge clk);
    chk("rst_async", 1, obs(), 12'h000);
    reset = 1'b0;
    mdl_note = '0;
    @(negedge clk);
    play(0, 0, -1);

    // rest entry followed by a short tone
    mdl_mem[0] = 8'hD3;
    mdl_mem[1] = 8'h11;
    mdl_mem[2] = 8'h00;
    load();
    play(0, 0, -1);

    // looped two-entry pattern, stopped inside the second pass of entry 0
    mdl_mem[0] = 8'h12;
    mdl_mem[1] = 8'h31;
    mdl_mem[2] = 8'h00;
    load();
    play(1, 0, 22);

    // writes and start pulses while playing are ignored; the replay proves RAM untouched
    play(0, 1, -1);
    play(0, 0, -1);

    // empty pattern with loop set still finishes
    mdl_mem[0] = 8'h00;
    load();
    play(1, 0, -1);

    // all 16 entries populated: one-shot end after entry 15, then looped past the wrap
    fill_random(2, 0);
    load();
    play(0, 0, -1);
    play(1, 0, 16 * (2 * TD + GC + 1) + 10);

    for (int r = 0; r < 10; r++) begin
      bit lp;
      bit jk;
      int sr;
      fill_random(6, 1);
      load();
      lp = 1'($urandom_range(0, 1));
      jk = 1'($urandom_range(0, 1));
      sr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -1;
      play(lp, jk, sr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
